control_unit: RTL and testbench

Hardwired sequencer for the datapath: drives every per-cycle control strobe the datapath consumes, replacing hand-sequenced stimulus. Runs the three-cycle fetch (T0–T2), decodes the instruction held in IR, and sequences the execute steps for three-register ALU ops, mul/div, mfhi/mflo, nop and halt. Sits beside `datapath`; its outputs connect one-to-one to the datapath control inputs, and its `ir` input is the datapath IR register output.

---
 rtl/control_unit.sv | 192 +++++++++++++++++++
 tb/tb_control_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Hardwired sequencer for the datapath: fetch T0-T2, decode IR,
// then sequence ALU, mul/div, mfhi/mflo, nop and halt execute steps.
module control_unit (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    output logic        PCout,
    output logic        incPC,
    output logic        MARin,
    output logic        PCin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        ZLowOut,
    output logic        ZHighOut,
    output logic        HIin,
    output logic        LOin,
    output logic        HIout,
    output logic        LOout,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic [15:0] instr_count
);

    typedef enum logic [3:0] {
        S_RESET = 4'd0,
        S_T0    = 4'd1,
        S_T1    = 4'd2,
        S_T2    = 4'd3,
        S_T3    = 4'd4,
        S_T4    = 4'd5,
        S_T5    = 4'd6,
        S_T6    = 4'd7,
        S_HALT  = 4'd8
    } state_t;

    state_t      state;
    logic [15:0] cnt_q;

    logic [4:0] opcode;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       is_alu;
    logic       is_md;
    logic       is_mfhi;
    logic       is_mflo;
    logic       is_halt;
    logic       unused_ir;

    assign opcode    = ir[31:27];
    assign ra        = ir[26:23];
    assign rb        = ir[22:19];
    assign rc        = ir[18:15];
    assign unused_ir = ^ir[14:0];

    assign is_alu  = (opcode >= 5'd3) && (opcode <= 5'd11);
    assign is_md   = (opcode == 5'd15) || (opcode == 5'd16);
    assign is_mfhi = (opcode == 5'd24);
    assign is_mflo = (opcode == 5'd25);
    assign is_halt = (opcode == 5'd27);

    assign instr_count = cnt_q;

    // State sequencing and retired-instruction counting
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state <= S_RESET;
            cnt_q <= 16'd0;
        end else begin
            unique case (state)
                S_RESET: state <= S_T0;
                S_T0:    state <= S_T1;
                S_T1:    state <= S_T2;
                S_T2:    state <= S_T3;
                S_T3: begin
                    if (is_alu || is_md) begin
                        state <= S_T4;
                    end else if (is_halt) begin
                        state <= S_HALT;
                    end else begin
                        state <= S_T0;
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_T4:    state <= S_T5;
                S_T5: begin
                    if (is_md) begin
                        state <= S_T6;
                    end else begin
                        state <= S_T0;
                        cnt_q <= cnt_q + 16'd1;
                    end
                end
                S_T6: begin
                    state <= S_T0;
                    cnt_q <= cnt_q + 16'd1;
                end
                S_HALT:  state <= S_HALT;
                default: state <= S_RESET;
            endcase
        end
    end

    // Per-state strobe decode from the current state and IR fields
    always_comb begin
        PCout    = 1'b0;
        incPC    = 1'b0;
        MARin    = 1'b0;
        PCin     = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        ZLowOut  = 1'b0;
        ZHighOut = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        HIout    = 1'b0;
        LOout    = 1'b0;
        Rin      = 16'd0;
        Rout     = 16'd0;
        alu_op   = 5'd0;
        run      = (state != S_HALT);
        unique case (state)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                incPC = 1'b1;
                Zin   = 1'b1;
            end
            S_T1: begin
                ZLowOut = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (is_alu) begin
                    Rout = 16'd1 << rb;
                    Yin  = 1'b1;
                end else if (is_md) begin
                    Rout = 16'd1 << ra;
                    Yin  = 1'b1;
                end else if (is_mfhi) begin
                    HIout = 1'b1;
                    Rin   = 16'd1 << ra;
                end else if (is_mflo) begin
                    LOout = 1'b1;
                    Rin   = 16'd1 << ra;
                end
            end
            S_T4: begin
                if (is_alu) begin
                    Rout   = 16'd1 << rc;
                    alu_op = opcode;
                    Zin    = 1'b1;
                end else if (is_md) begin
                    Rout   = 16'd1 << rb;
                    alu_op = opcode;
                    Zin    = 1'b1;
                end
            end
            S_T5: begin
                ZLowOut = 1'b1;
                if (is_md) begin
                    LOin = 1'b1;
                end else begin
                    Rin = 16'd1 << ra;
                end
            end
            S_T6: begin
                ZHighOut = 1'b1;
                HIin     = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: table of instructions with per-state
// expected strobes, queued at drive time and checked at negedge.
module tb_control_unit;

    logic        clk;
    logic        clr;
    logic [31:0] ir;
    logic        PCout, incPC, MARin, PCin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout;
    logic [15:0] Rin, Rout;
    logic [4:0]  alu_op;
    logic        run;
    logic [15:0] instr_count;

    control_unit dut (
        .clk(clk), .clr(clr), .ir(ir),
        .PCout(PCout), .incPC(incPC), .MARin(MARin), .PCin(PCin),
        .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
        .Yin(Yin), .Zin(Zin), .ZLowOut(ZLowOut), .ZHighOut(ZHighOut),
        .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
        .Rin(Rin), .Rout(Rout), .alu_op(alu_op), .run(run),
        .instr_count(instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  fet;
        logic [7:0]  exe;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [4:0]  alu;
        logic        run;
    } out_t;

    typedef struct {
        string       nm;
        logic [31:0] ir;
        int          n;
        out_t        e[4];
    } vec_t;

    // fet: {PCout,incPC,MARin,PCin,Read,MDRin,MDRout,IRin}
    // exe: {Yin,Zin,ZLowOut,ZHighOut,HIin,LOin,HIout,LOout}
    localparam logic [7:0] X_Y  = 8'h80;
    localparam logic [7:0] X_Z  = 8'h40;
    localparam logic [7:0] X_ZL = 8'h20;
    localparam logic [7:0] X_ZH = 8'h10;
    localparam logic [7:0] X_HI = 8'h08;
    localparam logic [7:0] X_LI = 8'h04;
    localparam logic [7:0] X_HO = 8'h02;
    localparam logic [7:0] X_LO = 8'h01;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;
    out_t exp_q[$];
    out_t E_T0, E_T1, E_T2, E_NONE, E_HALT;
    vec_t vt[11];

    function automatic out_t mk(logic [7:0] f, logic [7:0] x,
                                logic [15:0] ri, logic [15:0] ro,
                                logic [4:0] a, logic r);
        out_t o;
        o.fet = f; o.exe = x; o.rin = ri; o.rout = ro;
        o.alu = a; o.run = r;
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.fet  = {PCout, incPC, MARin, PCin, Read, MDRin, MDRout, IRin};
        o.exe  = {Yin, Zin, ZLowOut, ZHighOut, HIin, LOin, HIout, LOout};
        o.rin  = Rin;
        o.rout = Rout;
        o.alu  = alu_op;
        o.run  = run;
        return o;
    endfunction

    task automatic chk_now(input out_t e, input string nm);
        out_t got, want;
        exp_q.push_back(e);
        got  = sample();
        want = exp_q.pop_front();
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, got, want);
        end
    endtask

    task automatic chkc(input string nm);
        tests++;
        if (instr_count !== 16'(exp_cnt)) begin
            fails++;
            $display("FAIL %s count: got %h required %h",
                     nm, instr_count, 16'(exp_cnt));
        end
    endtask

    task automatic step(input out_t e, input string nm);
        out_t got, want;
        exp_q.push_back(e);
        @(negedge clk);
        got  = sample();
        want = exp_q.pop_front();
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h required %h", nm, got, want);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input string nm);
        ir = $urandom();
        step(E_T0, {nm, "_T0"});
        ir = $urandom();
        step(E_T1, {nm, "_T1"});
        ir = $urandom();
        step(E_T2, {nm, "_T2"});
    endtask

    task automatic run_instr(input vec_t v);
        fetch(v.nm);
        ir = v.ir;
        for (int i = 0; i < v.n; i++)
            step(v.e[i], $sformatf("%s_T%0d", v.nm, i + 3));
        exp_cnt = (exp_cnt + 1) & 16'hFFFF;
        chkc(v.nm);
    endtask

    task automatic do_reset(input string nm);
        #2 clr = 1'b0;
        #1 chk_now(E_NONE, {nm, "_async"});
        exp_cnt = 0;
        chkc({nm, "_async"});
        @(posedge clk);
        #1 chk_now(E_NONE, {nm, "_held"});
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr = 1'b0;
        ir  = 32'd0;
        E_T0   = mk(8'hE0, X_Z, 16'd0, 16'd0, 5'd0, 1'b1);
        E_T1   = mk(8'h1C, X_ZL, 16'd0, 16'd0, 5'd0, 1'b1);
        E_T2   = mk(8'h03, 8'h00, 16'd0, 16'd0, 5'd0, 1'b1);
        E_NONE = mk(8'h00, 8'h00, 16'd0, 16'd0, 5'd0, 1'b1);
        E_HALT = mk(8'h00, 8'h00, 16'd0, 16'd0, 5'd0, 1'b0);

        vt[0] = '{"and", 32'h5091_8000, 3, '{
            mk(0, X_Y, 0, 16'h0004, 0, 1),
            mk(0, X_Z, 0, 16'h0008, 5'b01010, 1),
            mk(0, X_ZL, 16'h0002, 0, 0, 1), E_NONE}};
        vt[1] = '{"mul", 32'h7918_0000, 4, '{
            mk(0, X_Y, 0, 16'h0004, 0, 1),
            mk(0, X_Z, 0, 16'h0008, 5'b01111, 1),
            mk(0, X_ZL | X_LI, 0, 0, 0, 1),
            mk(0, X_ZH | X_HI, 0, 0, 0, 1)}};
        vt[2] = '{"mflo", 32'hCA80_0000, 1, '{
            mk(0, X_LO, 16'h0020, 0, 0, 1), E_NONE, E_NONE, E_NONE}};
        vt[3] = '{"undef31", 32'hF800_0000, 1, '{
            E_NONE, E_NONE, E_NONE, E_NONE}};
        vt[4] = '{"add_r0", {5'b00011, 4'hF, 4'h0, 4'h7, 15'h1234}, 3, '{
            mk(0, X_Y, 0, 16'h0001, 0, 1),
            mk(0, X_Z, 0, 16'h0080, 5'b00011, 1),
            mk(0, X_ZL, 16'h8000, 0, 0, 1), E_NONE}};
        vt[5] = '{"or", {5'b01011, 4'h3, 4'h4, 4'h5, 15'h0}, 3, '{
            mk(0, X_Y, 0, 16'h0010, 0, 1),
            mk(0, X_Z, 0, 16'h0020, 5'b01011, 1),
            mk(0, X_ZL, 16'h0008, 0, 0, 1), E_NONE}};
        vt[6] = '{"div", {5'b10000, 4'hE, 4'h9, 19'h0}, 4, '{
            mk(0, X_Y, 0, 16'h4000, 0, 1),
            mk(0, X_Z, 0, 16'h0200, 5'b10000, 1),
            mk(0, X_ZL | X_LI, 0, 0, 0, 1),
            mk(0, X_ZH | X_HI, 0, 0, 0, 1)}};
        vt[7] = '{"mfhi_r0", {5'b11000, 27'h0}, 1, '{
            mk(0, X_HO, 16'h0001, 0, 0, 1), E_NONE, E_NONE, E_NONE}};
        vt[8] = '{"nop", 32'hD000_0000, 1, '{
            E_NONE, E_NONE, E_NONE, E_NONE}};
        vt[9] = '{"undef0", {5'b00000, 4'h1, 4'h2, 4'h3, 15'h0}, 1, '{
            E_NONE, E_NONE, E_NONE, E_NONE}};
        vt[10] = '{"undef12", {5'b01100, 4'h1, 4'h2, 4'h3, 15'h0}, 1, '{
            E_NONE, E_NONE, E_NONE, E_NONE}};

        #1 chk_now(E_NONE, "reset_init");
        chkc("reset_init");
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;

        foreach (vt[i]) run_instr(vt[i]);

        // abort AND in T4 with async reset
        fetch("and_abort");
        ir = vt[0].ir;
        step(vt[0].e[0], "and_abort_T3");
        chk_now(vt[0].e[1], "and_abort_T4");
        do_reset("rst_midT4");

        // wrap of the counter across a nop
        ir = $urandom();
        step(E_T0, "wrap_T0");
        force dut.cnt_q = 16'hFFFF;
        #1 release dut.cnt_q;
        exp_cnt = 16'hFFFF;
        chkc("wrap_preload");
        step(E_T1, "wrap_T1");
        step(E_T2, "wrap_T2");
        ir = 32'hD000_0000;
        step(E_NONE, "wrap_T3");
        exp_cnt = 0;
        chkc("wrap");
        run_instr(vt[2]);

        // halt: parks with run low, count frozen
        fetch("halt");
        ir = 32'hD800_0000;
        step(E_NONE, "halt_T3");
        for (int i = 0; i < 20; i++) begin
            ir = $urandom();
            step(E_HALT, $sformatf("halt_c%0d", i));
        end
        chkc("halt");
        do_reset("rst_halt");
        run_instr(vt[1]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
